// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: default widths and mode/direction encodings.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int PWM_N_CH  = 4;
  localparam int PWM_PRE_W = 8;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: free-runs 0..prescale while enabled and flags the terminal count as a tick.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRE_W = PWM_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;

  assign tick = en && (cnt_q == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM generator with edge/center-aligned counting and double-buffered duty,
// period and mode registers that reload at each cycle boundary or while disabled.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int  CNT_W = PWM_CNT_W,
  parameter int  N_CH  = PWM_N_CH,
  parameter int  PRE_W = PWM_PRE_W,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] period,
  input  logic             duty_wr_en,
  input  logic [CH_W-1:0]  duty_wr_ch,
  input  logic [CNT_W-1:0] duty_wr_data,
  output logic [N_CH-1:0]  pwm_out,
  output logic [CNT_W-1:0] pwm_counter,
  output logic             pwm_cycle_end
);

  logic             tick;
  logic             boundary;
  logic             load;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwm_dir_e         dir_q, dir_d;
  pwm_mode_e        act_mode;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] shadow_duty [N_CH];
  logic [CNT_W-1:0] act_duty    [N_CH];
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  cmp;

  pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .prescale (prescale),
    .tick     (tick)
  );

  // Out-of-range channel numbers match no entry, so such writes fall away.
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      wr_hit[i] = duty_wr_en && (32'(duty_wr_ch) == i);
    end
  end

  assign boundary = tick && (cnt_d == '0);
  assign load     = !en || boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_duty <= '{default: '0};
      act_duty    <= '{default: '0};
      act_period  <= '0;
      act_mode    <= MODE_EDGE;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (wr_hit[i]) shadow_duty[i] <= duty_wr_data;
        // A write landing on the reload clock bypasses the shadow straight into the active copy.
        if (load) act_duty[i] <= wr_hit[i] ? duty_wr_data : shadow_duty[i];
      end
      if (load) begin
        act_period <= period;
        act_mode   <= pwm_mode_e'(mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (act_period == '0) begin
        cnt_d = '0;
      end else if (act_mode == MODE_EDGE) begin
        cnt_d = (cnt_q >= act_period) ? '0 : cnt_q + CNT_W'(1);
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= act_period) begin
          cnt_d = cnt_q - CNT_W'(1);
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      // Reaching zero always re-arms the up direction (covers period=1 in center mode).
      if (cnt_d == '0) dir_d = DIR_UP;
    end
  end

  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cmp[i] = cnt_q < act_duty[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out       <= '0;
      pwm_cycle_end <= 1'b0;
    end else if (!en) begin
      pwm_out       <= '0;
      pwm_cycle_end <= 1'b0;
    end else begin
      pwm_out       <= cmp;
      pwm_cycle_end <= boundary;
    end
  end

  assign pwm_counter = cnt_q;

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the counter and duty width.
REQ-002 SHALL have parameter N_CH, default 4, giving the number of PWM output channels.
REQ-003 SHALL have parameter PRE_W, default 8, giving the prescaler width.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- mode  in  1  0 = edge-aligned, 1 = center-aligned.
- prescale  in  PRE_W  one tick every prescale+1 clocks.
- period  in  CNT_W  counter top value.
- duty_wr_en  in  1  duty shadow write strobe.
- duty_wr_ch  in  max(1,$clog2(N_CH))  channel to write.
- duty_wr_data  in  CNT_W  duty value.
- pwm_out  out  N_CH  PWM outputs.
- pwm_counter  out  CNT_W  current count.
- pwm_cycle_end  out  1  one-clock pulse at each cycle boundary.

Function
REQ-005 SHALL run the prescaler 0..prescale and assert an internal tick on the clock where it equals prescale, then wrap it to 0; prescale=0 SHALL tick every clock.
REQ-006 SHALL, in edge mode, increment pwm_counter on each tick from 0 to active period, then wrap to 0 on the next tick.
REQ-007 SHALL, in center mode, count up from 0 to active period and down to 0, giving 2*period ticks per cycle, with direction reversing at period and at 0.
REQ-008 SHALL hold pwm_counter at 0 and pulse pwm_cycle_end on every tick when active period=0, in either mode.
REQ-009 SHALL define the cycle boundary as the tick that returns pwm_counter to 0, and SHALL assert pwm_cycle_end for exactly one clock in the clock after that tick.
REQ-010 SHALL write duty_wr_data into shadow duty[duty_wr_ch] when duty_wr_en=1, and SHALL ignore writes with duty_wr_ch >= N_CH.
REQ-011 SHALL copy all shadow duties, period and mode into the active registers at each cycle boundary, and on every clock while en=0.
REQ-012 SHALL, when a shadow write coincides with a boundary load, give that channel's active duty the newly written value.
REQ-013 SHALL register pwm_out[i] = (pwm_counter < active duty[i]), one clock after the counter value.
REQ-014 SHALL produce these duty boundary cases:
- duty=0: output constantly low.
- edge mode, duty > period: output constantly high.
- center mode, duty > period: output constantly high.
REQ-015 SHALL, while en=0, hold the prescaler and counter at 0 with direction up, force pwm_out and pwm_cycle_end low, and still accept shadow writes.
REQ-016 SHALL, on en rising, start counting from 0 using the freshly loaded active values.
REQ-017 SHALL ignore changes to the period and mode inputs mid-cycle; they SHALL take effect only at a boundary or while en=0.

Reset
REQ-018 SHALL, on rst_n low, immediately clear to 0: prescaler, counter, direction (up), pwm_out, pwm_cycle_end, and all shadow and active duty, period and mode registers.
REQ-019 SHALL abandon any cycle in progress if reset is asserted mid-cycle, with no pulse on pwm_cycle_end.

Structure
REQ-020 SHALL take MODE_EDGE/MODE_CENTER encodings and the default CNT_W, N_CH and PRE_W from shared package pwm_pkg.
REQ-021 SHALL implement the prescaler as sub-module pwm_prescaler (inputs clk, rst_n, en, prescale; output tick).

Verification
REQ-022 SHALL cover these directed scenarios:
- Reset check: assert rst_n low mid-run -> all outputs 0 at once; no pwm_cycle_end after release until the first boundary.
- Edge mode: prescale=0, period=9, ch0 duty=3 -> ch0 high 3 of every 10 clocks; pwm_cycle_end every 10 clocks.
- Center mode: prescale=0, period=4, duty=2 -> counter 0,1,2,3,4,3,2,1 repeating; ch high 3 of 8 clocks.
- Double buffer: ch1 duty=2, write 7 mid-cycle (edge, period=9) -> output stays 2-wide until boundary, then 7-wide; a write on the boundary clock takes effect immediately.
- Extremes: prescale=3, duty=0 and duty=12 with period=9 -> constant low and constant high; ticks every 4 clocks.
- Enable drop: en low at count 5 -> counter 0, outputs low next clock; en high -> restarts at 0 with the latest shadow values.
